// File: rtl/mem_dump_ctrl_pkg.sv
// Shared types and constants for the memory dump sequencer.
// Holds the FSM state encoding, the stream source tags and the default source depths.
package mem_dump_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHalt,
    StIssue,
    StCapt,
    StSend,
    StDone
  } state_e;

  localparam logic [1:0] TAG_IMEM  = 2'b00;
  localparam logic [1:0] TAG_DMEM  = 2'b01;
  localparam logic [1:0] TAG_REG   = 2'b10;
  localparam logic [1:0] TAG_FLAGS = 2'b11;

  localparam int unsigned DEF_IMEM_AW = 9;
  localparam int unsigned DEF_DMEM_AW = 8;
  localparam int unsigned DEF_NREGS   = 16;
  localparam int unsigned IDX_W       = 9;
  localparam int unsigned DRAIN_W     = 4;

  localparam int unsigned IMEM_DEPTH  = 2 ** DEF_IMEM_AW;
  localparam int unsigned DMEM_DEPTH  = 2 ** DEF_DMEM_AW;
  localparam int unsigned REG_DEPTH   = DEF_NREGS;
  localparam int unsigned TOTAL_WORDS = IMEM_DEPTH + DMEM_DEPTH + REG_DEPTH + 1;

  // Source order is IMEM -> DMEM -> REG -> FLAGS; wraps back to IMEM after FLAGS.
  function automatic logic [1:0] next_tag(input logic [1:0] tag);
    return tag + 2'b01;
  endfunction

endpackage

// File: rtl/mem_dump_ctrl.sv
// Dump sequencer: halts the core, reads IMEM, DMEM, register file and flags through the
// external debug read ports and streams each word out on a valid/ready interface.
module mem_dump_ctrl
  import mem_dump_ctrl_pkg::*;
#(
  parameter int unsigned IMEM_AW     = DEF_IMEM_AW,
  parameter int unsigned DMEM_AW     = DEF_DMEM_AW,
  parameter int unsigned NREGS       = DEF_NREGS,
  parameter int unsigned HALT_CYCLES = 5
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic               pipe_en_in,
  output logic               pipe_en,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic               imem_re,
  input  logic [31:0]        imem_out,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic               dmem_re_external,
  input  logic [31:0]        dmem_out,
  output logic [3:0]         reg_addr,
  output logic               reg_re,
  input  logic [31:0]        reg_out,
  input  logic               N,
  input  logic               Z,
  input  logic               C,
  input  logic               V,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        out_data,
  output logic [1:0]         out_tag,
  output logic [8:0]         out_idx,
  output logic               out_last,
  output logic               busy,
  output logic               done
);

  localparam logic [IDX_W-1:0]   ImemLast = IDX_W'(2 ** IMEM_AW - 1);
  localparam logic [IDX_W-1:0]   DmemLast = IDX_W'(2 ** DMEM_AW - 1);
  localparam logic [IDX_W-1:0]   RegLast  = IDX_W'(NREGS - 1);
  localparam logic [DRAIN_W-1:0] DrainLd  = DRAIN_W'(HALT_CYCLES);

  state_e               state_q, state_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [1:0]           src_q, src_d;
  logic                 pipe_en_q, pipe_en_d;
  logic [31:0]          out_data_q, out_data_d;
  logic [1:0]           out_tag_q, out_tag_d;
  logic [8:0]           out_idx_q, out_idx_d;
  logic                 out_last_q, out_last_d;
  logic                 idx_at_end;
  logic                 issue;

  // Per-source depth compare; idx never relies on natural overflow.
  always_comb begin
    idx_at_end = 1'b0;
    unique case (src_q)
      TAG_IMEM:  idx_at_end = (idx_q == ImemLast);
      TAG_DMEM:  idx_at_end = (idx_q == DmemLast);
      TAG_REG:   idx_at_end = (idx_q == RegLast);
      TAG_FLAGS: idx_at_end = 1'b1;
      default:   idx_at_end = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (start) state_d = StHalt;
      StHalt:  if (drain_q <= DRAIN_W'(1)) state_d = StIssue;
      StIssue: state_d = StCapt;
      StCapt:  state_d = StSend;
      StSend: begin
        if (out_ready) state_d = (src_q == TAG_FLAGS) ? StDone : StIssue;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next-state: drain counter, source/index walk, captured output word.
  always_comb begin
    drain_d    = drain_q;
    idx_d      = idx_q;
    src_d      = src_q;
    pipe_en_d  = pipe_en_q;
    out_data_d = out_data_q;
    out_tag_d  = out_tag_q;
    out_idx_d  = out_idx_q;
    out_last_d = out_last_q;
    unique case (state_q)
      StIdle: begin
        pipe_en_d = pipe_en_in;
        if (start) begin
          pipe_en_d = 1'b0;
          drain_d   = DrainLd;
          src_d     = TAG_IMEM;
          idx_d     = '0;
        end
      end
      StHalt: drain_d = drain_q - DRAIN_W'(1);
      StCapt: begin
        unique case (src_q)
          TAG_IMEM:  out_data_d = imem_out;
          TAG_DMEM:  out_data_d = dmem_out;
          TAG_REG:   out_data_d = reg_out;
          TAG_FLAGS: out_data_d = {28'b0, N, Z, C, V};
          default:   out_data_d = '0;
        endcase
        out_tag_d  = src_q;
        out_idx_d  = idx_q;
        out_last_d = (src_q == TAG_FLAGS);
      end
      StSend: begin
        if (out_ready) begin
          if (idx_at_end) begin
            src_d = next_tag(src_q);
            idx_d = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      // Reload from the host on the way out so pipe_en is live in the first IDLE cycle.
      StDone:  pipe_en_d = pipe_en_in;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drain_q    <= '0;
      idx_q      <= '0;
      src_q      <= TAG_IMEM;
      pipe_en_q  <= 1'b0;
      out_data_q <= '0;
      out_tag_q  <= '0;
      out_idx_q  <= '0;
      out_last_q <= 1'b0;
    end else begin
      drain_q    <= drain_d;
      idx_q      <= idx_d;
      src_q      <= src_d;
      pipe_en_q  <= pipe_en_d;
      out_data_q <= out_data_d;
      out_tag_q  <= out_tag_d;
      out_idx_q  <= out_idx_d;
      out_last_q <= out_last_d;
    end
  end

  // Outputs decoded from state and the source select.
  always_comb begin
    issue            = (state_q == StIssue);
    imem_re          = issue && (src_q == TAG_IMEM);
    dmem_re_external = issue && (src_q == TAG_DMEM);
    reg_re           = issue && (src_q == TAG_REG);
    imem_addr        = (src_q == TAG_IMEM) ? idx_q[IMEM_AW-1:0] : '0;
    dmem_addr        = (src_q == TAG_DMEM) ? idx_q[DMEM_AW-1:0] : '0;
    reg_addr         = (src_q == TAG_REG)  ? idx_q[3:0]         : '0;
    out_valid        = (state_q == StSend);
    busy             = (state_q != StIdle);
    done             = (state_q == StDone);
    pipe_en          = pipe_en_q;
    out_data         = out_data_q;
    out_tag          = out_tag_q;
    out_idx          = out_idx_q;
    out_last         = out_last_q;
  end

endmodule

// File: tb/tb_mem_dump_ctrl.sv
// Scoreboard bench for mem_dump_ctrl: behavioural memories, a free-running core PC and an
// expected-word queue compared against every stream handshake.
module tb_mem_dump_ctrl;
  import mem_dump_ctrl_pkg::*;

  localparam int H      = 5;
  localparam int NWORDS = 785;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic        pipe_en_in = 1'b0;
  logic        pipe_en;
  logic [8:0]  imem_addr;
  logic        imem_re;
  logic [31:0] imem_out = '0;
  logic [7:0]  dmem_addr;
  logic        dmem_re_external;
  logic [31:0] dmem_out = '0;
  logic [3:0]  reg_addr;
  logic        reg_re;
  logic [31:0] reg_out = '0;
  logic        flag_n = 1'b1, flag_z = 1'b0, flag_c = 1'b1, flag_v = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_data;
  logic [1:0]  out_tag;
  logic [8:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        done;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic [31:0] pc;
  logic [43:0] sb_q[$];

  mem_dump_ctrl #(
    .IMEM_AW(9), .DMEM_AW(8), .NREGS(16), .HALT_CYCLES(H)
  ) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .pipe_en_in(pipe_en_in), .pipe_en(pipe_en),
    .imem_addr(imem_addr), .imem_re(imem_re), .imem_out(imem_out),
    .dmem_addr(dmem_addr), .dmem_re_external(dmem_re_external), .dmem_out(dmem_out),
    .reg_addr(reg_addr), .reg_re(reg_re), .reg_out(reg_out),
    .N(flag_n), .Z(flag_z), .C(flag_c), .V(flag_v),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag),
    .out_idx(out_idx), .out_last(out_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Synchronous-read memories: IMEM[i]=i, DMEM[i]=~i, REG[i]=0xA0+i.
  always @(posedge clk) begin
    if (imem_re) imem_out <= {23'b0, imem_addr};
    if (dmem_re_external) dmem_out <= ~{24'b0, dmem_addr};
    if (reg_re) reg_out <= 32'hA0 + {28'b0, reg_addr};
  end

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc <= '0;
    else if (pipe_en) pc <= pc + 32'd1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [43:0] exp_word(input int k);
    int j;
    if (k < 512) begin
      return {1'b0, TAG_IMEM, 9'(k), 32'(k)};
    end else if (k < 768) begin
      j = k - 512;
      return {1'b0, TAG_DMEM, 9'(j), ~32'(j)};
    end else if (k < 784) begin
      j = k - 768;
      return {1'b0, TAG_REG, 9'(j), 32'hA0 + 32'(j)};
    end
    return {1'b1, TAG_FLAGS, 9'd0, 32'h0000_000A};
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_ctl"},
             64'({pipe_en, imem_re, dmem_re_external, reg_re, imem_addr, dmem_addr, reg_addr,
                  out_valid, busy, done, out_last, out_tag}), 64'd0);
    check_eq({tag, "_data"}, 64'({out_idx, out_data}), 64'd0);
  endtask

  task automatic run_dump(input bit bp, input int glitch_at, input int abort_at,
                          input bit chk_timing);
    int          nwords = 0, ndone = 0, e0 = 0, pe_bad = 0, tail = 0;
    bit          stall = 0, seen_valid = 0, glitched = 0, done_prev = 0, finished = 0;
    logic [31:0] pc0;
    logic [43:0] cur, held;
    logic [11:0] re_got, re_exp;
    held = '0;
    sb_q.delete();
    for (int k = 0; k < NWORDS; k++) sb_q.push_back(exp_word(k));
    @(negedge clk);
    pipe_en_in = 1'b1;
    out_ready  = 1'b1;
    start      = 1'b1;
    @(posedge clk);
    #1;
    e0    = cyc;
    pc0   = pc;
    start = 1'b0;
    check_eq("pipe_en_low_after_e0", 64'(pipe_en), 64'd0);
    for (int c = 0; c < 12000 && !finished; c++) begin
      @(negedge clk);
      if (busy && pipe_en) pe_bad++;
      if (abort_at >= 0 && nwords == abort_at) begin
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort_reset");
        @(negedge clk);
        reset_n = 1'b1;
        sb_q.delete();
        return;
      end
      cur = {out_last, out_tag, out_idx, out_data};
      if (stall) begin
        check_eq("stall_valid", 64'(out_valid), 64'd1);
        check_eq("stall_hold", 64'(cur), 64'(held));
      end
      if ((imem_re || dmem_re_external || reg_re) && sb_q.size() > 0) begin
        unique case (sb_q[0][42:41])
          TAG_IMEM: re_exp = {3'b100, sb_q[0][40:32]};
          TAG_DMEM: re_exp = {3'b010, sb_q[0][40:32]};
          TAG_REG:  re_exp = {3'b001, sb_q[0][40:32]};
          default:  re_exp = {3'b000, sb_q[0][40:32]};
        endcase
        re_got = {imem_re, dmem_re_external, reg_re,
                  imem_re ? imem_addr : dmem_re_external ? {1'b0, dmem_addr} : {5'b0, reg_addr}};
        check_eq("re_addr", 64'(re_got), 64'(re_exp));
      end
      if (out_valid && !seen_valid) begin
        seen_valid = 1;
        if (chk_timing) check_eq("first_valid_cyc", 64'(cyc), 64'(e0 + H + 2));
      end
      if (done_prev && !finished) begin
        check_eq("pipe_en_after_done", 64'(pipe_en), 64'd1);
        check_eq("busy_after_done", 64'(busy), 64'd0);
        finished = 1;
      end
      if (done) begin
        ndone++;
        done_prev = 1;
        if (ndone == 1) begin
          if (chk_timing) check_eq("done_cyc", 64'(cyc), 64'(e0 + H + 3 * NWORDS));
          check_eq("pc_frozen", 64'(pc), 64'(pc0));
          check_eq("pipe_en_busy_low", 64'(pe_bad), 64'd0);
        end
      end
      start = 1'b0;
      if (glitch_at >= 0 && nwords == glitch_at && !glitched) begin
        start    = 1'b1;
        glitched = 1;
      end
      pipe_en_in = (bp && busy && !done) ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready  = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) check_eq("extra_word", 64'(cur), 64'd0 - 64'd1);
        else check_eq($sformatf("word%0d", nwords), 64'(cur), 64'(sb_q.pop_front()));
        nwords++;
      end
      stall = out_valid && !out_ready;
      held  = cur;
    end
    if (!finished) check_eq("timeout", 64'd0, 64'd1);
    start     = 1'b0;
    out_ready = 1'b1;
    for (tail = 0; tail < 20; tail++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check_eq("word_count", 64'(nwords), 64'(NWORDS));
    check_eq("done_pulses", 64'(ndone), 64'd1);
    check_eq("sb_empty", 64'(sb_q.size()), 64'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_reset_outputs("por_reset");
    reset_n    = 1'b1;
    pipe_en_in = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("pipe_en_follows", 64'(pipe_en), 64'd1);
    check_eq("idle_not_busy", 64'(busy), 64'd0);

    run_dump(1'b0, -1, -1, 1'b1);
    run_dump(1'b1, -1, -1, 1'b0);
    run_dump(1'b0, -1, 100, 1'b0);
    run_dump(1'b0, 300, -1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
